fci_bridge: RTL and testbench

FPGA-side receiver for the FCI bus driven by the TSXB board CPLD. It synchronises the ZX-BUS strobes (FRD/FWR/FMRQ/FIORQ) and steps the CPLD multiplexer through address-low, address-high and data via FCI_S. It turns each Z80 memory or I/O access into a single req/ack transaction on the internal FPGA bus. For claimed reads it turns FCI around and drives the read byte back through the CPLD onto ZD.

---
 rtl/tsxb_fci_pkg.sv | 22 ++
 rtl/fci_strobe_sync.sv | 21 ++
 rtl/fci_bridge.sv | 147 ++++++++++++++
 tb/tb_fci_bridge.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsxb_fci_pkg.sv
// Shared constants for the TSXB FCI bridge: CPLD mux select codes and the
// bridge FSM state encoding.
package tsxb_fci_pkg;

  localparam logic [1:0] FCI_ZAL = 2'd0;
  localparam logic [1:0] FCI_ZAH = 2'd1;
  localparam logic [1:0] FCI_ZD  = 2'd2;
  localparam logic [1:0] FCI_ZC  = 2'd3;

  typedef enum logic [3:0] {
    IDLE,
    CAP_AL,
    CAP_AH,
    CAP_D,
    REQ,
    TURN_ON,
    DRIVE,
    TURN_OFF,
    WAIT_END
  } fci_state_t;

endpackage

// File: rtl/fci_strobe_sync.sv
// Two-flop synchroniser for the four ZX-BUS strobes coming from the CPLD.
module fci_strobe_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] async_in,
  output logic [3:0] sync_out
);

  logic [3:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= '0;
      sync_out <= '0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/fci_bridge.sv
// FCI bus receiver: steps the CPLD mux through address/data, issues one
// req/ack transaction per Z80 access and drives claimed read data back.
import tsxb_fci_pkg::*;

module fci_bridge #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frd,
  input  logic        fwr,
  input  logic        fmrq,
  input  logic        fiorq,
  input  logic [7:0]  fci_in,
  output logic [7:0]  fci_out,
  output logic        fci_oe,
  output logic [1:0]  fci_s,
  output logic        fdir,
  output logic        bus_req,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_we,
  output logic        bus_io,
  input  logic        bus_ack,
  input  logic        bus_hit,
  input  logic [7:0]  bus_rdata,
  output logic        busy
);

  localparam logic [3:0] CAP_LAST  = 4'(SETTLE);
  localparam logic [3:0] TURN_LAST = 4'(SETTLE - 1);

  logic [3:0] strobe_s;
  logic       frd_s, fwr_s, fmrq_s, fiorq_s;
  logic       cyc, cyc_q, cyc_rise;

  fci_state_t state, state_next;
  logic [3:0] cnt;

  logic [1:0] fci_s_next;
  logic       fdir_next, fci_oe_next;

  fci_strobe_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in ({fiorq, fmrq, fwr, frd}),
    .sync_out (strobe_s)
  );

  assign frd_s    = strobe_s[0];
  assign fwr_s    = strobe_s[1];
  assign fmrq_s   = strobe_s[2];
  assign fiorq_s  = strobe_s[3];

  // Refresh and INTA carry no RD/WR, so they never form a cycle.
  assign cyc      = (fmrq_s | fiorq_s) & (frd_s | fwr_s);
  assign cyc_rise = cyc & ~cyc_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (cyc_rise) state_next = CAP_AL;
      CAP_AL:   if (!cyc) state_next = IDLE;
                else if (cnt == CAP_LAST) state_next = CAP_AH;
      CAP_AH:   if (!cyc) state_next = IDLE;
                else if (cnt == CAP_LAST) state_next = bus_we ? CAP_D : REQ;
      CAP_D:    if (!cyc) state_next = IDLE;
                else if (cnt == CAP_LAST) state_next = REQ;
      // The request is never withdrawn, even if the strobe has ended.
      REQ:      if (bus_ack)
                  state_next = (!bus_we && bus_hit && cyc) ? TURN_ON : WAIT_END;
      TURN_ON:  if (!cyc) state_next = TURN_OFF;
                else if (cnt == TURN_LAST) state_next = DRIVE;
      DRIVE:    if (!cyc) state_next = TURN_OFF;
      TURN_OFF: if (cnt == TURN_LAST) state_next = WAIT_END;
      WAIT_END: if (!cyc) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Pin controls are decoded from the next state and registered, so they
  // change glitch-free together with the state.
  always_comb begin
    fci_s_next  = FCI_ZD;
    fdir_next   = 1'b1;
    fci_oe_next = 1'b0;
    case (state_next)
      IDLE, CAP_AL: fci_s_next = FCI_ZAL;
      CAP_AH:       fci_s_next = FCI_ZAH;
      TURN_ON, TURN_OFF: fdir_next = 1'b0;
      DRIVE: begin
        fdir_next   = 1'b0;
        fci_oe_next = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      cyc_q   <= 1'b0;
      fci_s   <= FCI_ZAL;
      fdir    <= 1'b1;
      fci_oe  <= 1'b0;
      bus_req <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= (state_next != state) ? 4'd0 : cnt + 4'd1;
      cyc_q   <= cyc;
      fci_s   <= fci_s_next;
      fdir    <= fdir_next;
      fci_oe  <= fci_oe_next;
      bus_req <= (state_next == REQ);
      busy    <= (state_next != IDLE);
    end
  end

  // FCI is sampled on the last clock of each capture window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_we    <= 1'b0;
      bus_io    <= 1'b0;
      fci_out   <= '0;
    end else begin
      if (state == IDLE && cyc_rise) begin
        bus_io <= fiorq_s;
        bus_we <= fwr_s;
      end
      if (cyc && cnt == CAP_LAST) begin
        case (state)
          CAP_AL:  bus_addr[7:0]  <= fci_in;
          CAP_AH:  bus_addr[15:8] <= fci_in;
          CAP_D:   bus_wdata      <= fci_in;
          default: ;
        endcase
      end
      if (state == REQ && state_next == TURN_ON)
        fci_out <= bus_rdata;
    end
  end

endmodule

// File: tb/tb_fci_bridge.sv
// Scoreboard bench for fci_bridge: expected requests are queued by the
// stimulus and checked by a monitor when the bridge raises bus_req.
module tb_fci_bridge;

  localparam int SETTLE = 2;

  logic        clk, rst_n;
  logic        frd, fwr, fmrq, fiorq;
  logic [7:0]  fci_in, fci_out;
  logic        fci_oe, fdir;
  logic [1:0]  fci_s;
  logic        bus_req, bus_we, bus_io, bus_ack, bus_hit, busy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata, bus_rdata;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        io;
  } req_t;

  req_t        exp_q[$];
  logic [1:0]  s_hist[$];
  int          n_checks = 0, n_fail = 0, cyc_no = 0, req_count = 0;
  int          fdir_low_cnt = 0, oe_cnt = 0, busy_cnt = 0, conflict_cnt = 0;
  logic [15:0] za;
  logic [7:0]  zd;
  int          ack_delay;
  logic        resp_hit;
  logic [7:0]  resp_rdata;

  fci_bridge #(.SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frd       (frd),
    .fwr       (fwr),
    .fmrq      (fmrq),
    .fiorq     (fiorq),
    .fci_in    (fci_in),
    .fci_out   (fci_out),
    .fci_oe    (fci_oe),
    .fci_s     (fci_s),
    .fdir      (fdir),
    .bus_req   (bus_req),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_io    (bus_io),
    .bus_ack   (bus_ack),
    .bus_hit   (bus_hit),
    .bus_rdata (bus_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CPLD multiplexer model
  always_comb begin
    case (fci_s)
      2'd0:    fci_in = za[7:0];
      2'd1:    fci_in = za[15:8];
      default: fci_in = zd;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic mrq, input logic iorq, input logic rd, input logic wr);
    @(posedge clk); #2;
    fmrq = mrq; fiorq = iorq; frd = rd; fwr = wr;
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic waitSignal(input string name, input int sel, input logic val,
                            input int limit, output int at);
    logic cur;
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      case (sel)
        0:       cur = fdir;
        1:       cur = fci_oe;
        2:       cur = bus_req;
        3:       cur = busy;
        default: cur = (fci_s == 2'd1);
      endcase
      if (cur == val) begin
        at = cyc_no;
        break;
      end
    end
    if (at < 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: timeout after %0d clocks, expected level %0b", name, limit, val);
    end
  endtask

  task automatic pushExp(input logic [15:0] a, input logic [7:0] d, input logic we, input logic io);
    req_t e;
    e.addr = a; e.wdata = d; e.we = we; e.io = io;
    exp_q.push_back(e);
  endtask

  task automatic monitorLoop();
    logic  prev;
    logic [1:0] last_s;
    req_t  e;
    prev   = 1'b0;
    last_s = 2'd0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (fci_s != last_s) begin
          s_hist.push_back(fci_s);
          last_s = fci_s;
        end
        if (!fdir) fdir_low_cnt++;
        if (fci_oe) oe_cnt++;
        if (busy) busy_cnt++;
        if (fdir && fci_oe) conflict_cnt++;
      end
      if (bus_req && !prev) begin
        req_count++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_req: got addr 0x%0h, required no request", bus_addr);
        end else begin
          e = exp_q.pop_front();
          checkOutput("req_addr", 32'(bus_addr), 32'(e.addr));
          checkOutput("req_we", 32'(bus_we), 32'(e.we));
          checkOutput("req_io", 32'(bus_io), 32'(e.io));
          if (e.we) checkOutput("req_wdata", 32'(bus_wdata), 32'(e.wdata));
        end
      end
      prev = bus_req;
    end
  endtask

  task automatic responderLoop();
    int  wait_cnt;
    logic acked;
    wait_cnt = 0;
    acked    = 1'b0;
    forever begin
      @(posedge clk);
      cyc_no++;
      #2;
      bus_ack = 1'b0;
      if (!bus_req) acked = 1'b0;
      if (bus_req && !acked) begin
        if (wait_cnt == ack_delay) begin
          bus_ack   = 1'b1;
          bus_hit   = resp_hit;
          bus_rdata = resp_rdata;
          acked     = 1'b1;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t_a, t_b, t_c, t_drop, h0, fd0, oe0, bz0, rq0;
    rst_n = 1'b0;
    {frd, fwr, fmrq, fiorq} = 4'b0;
    bus_ack = 1'b0; bus_hit = 1'b0; bus_rdata = 8'h00;
    za = 16'h0; zd = 8'h0;
    ack_delay = 0; resp_hit = 1'b0; resp_rdata = 8'h00;

    fork
      monitorLoop();
      responderLoop();
    join_none

    waitClocks(3);
    @(negedge clk);
    checkOutput("rst_pins", {20'h0, fci_out, fci_oe, fci_s, fdir}, {20'h0, 8'h00, 1'b0, 2'd0, 1'b1});
    checkOutput("rst_bus", {bus_addr, bus_wdata}, 32'h0);
    checkOutput("rst_ctl", {28'h0, bus_req, bus_we, bus_io, busy}, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Memory write
    za = 16'hC123; zd = 8'h5A; resp_hit = 1'b0; ack_delay = 3;
    pushExp(16'hC123, 8'h5A, 1'b1, 1'b0);
    h0 = s_hist.size(); fd0 = fdir_low_cnt; oe0 = oe_cnt; rq0 = req_count;
    applyStimulus(1, 0, 0, 1);
    waitClocks(20);
    applyStimulus(0, 0, 0, 0);
    waitClocks(6);
    @(negedge clk);
    checkOutput("wr_idle", 32'(busy), 0);
    checkOutput("wr_req_count", req_count - rq0, 1);
    checkOutput("wr_s_changes", s_hist.size() - h0, 3);
    if (s_hist.size() - h0 == 3)
      checkOutput("wr_s_seq", {26'h0, s_hist[h0], s_hist[h0+1], s_hist[h0+2]}, {26'h0, 2'd1, 2'd2, 2'd0});
    checkOutput("wr_fdir_low", fdir_low_cnt - fd0, 0);
    checkOutput("wr_oe", oe_cnt - oe0, 0);

    // I/O read, claimed
    za = 16'hF8AF; resp_hit = 1'b1; resp_rdata = 8'h81; ack_delay = 0;
    pushExp(16'hF8AF, 8'h00, 1'b0, 1'b1);
    applyStimulus(0, 1, 1, 0);
    waitSignal("rd_fdir_fall", 0, 1'b0, 60, t_a);
    waitSignal("rd_oe_rise", 1, 1'b1, 20, t_b);
    checkOutput("rd_turn_on_clocks", t_b - t_a, SETTLE);
    checkOutput("rd_fci_out", 32'(fci_out), 32'h81);
    checkOutput("rd_drive_fdir", 32'(fdir), 0);
    waitClocks(5);
    applyStimulus(0, 0, 0, 0);
    t_drop = cyc_no;
    waitSignal("rd_oe_fall", 1, 1'b0, 10, t_b);
    checkOutput("rd_oe_off_latency", 32'((t_b - t_drop >= 3) && (t_b - t_drop <= 4)), 1);
    waitSignal("rd_fdir_rise", 0, 1'b1, 10, t_c);
    checkOutput("rd_turn_off_clocks", t_c - t_b, SETTLE);
    waitSignal("rd_idle", 3, 1'b0, 10, t_c);

    // Memory read, not claimed
    za = 16'h1234; resp_hit = 1'b0; resp_rdata = 8'hFF; ack_delay = 1;
    pushExp(16'h1234, 8'h00, 1'b0, 1'b0);
    fd0 = fdir_low_cnt; oe0 = oe_cnt; rq0 = req_count;
    applyStimulus(1, 0, 1, 0);
    waitClocks(25);
    applyStimulus(0, 0, 0, 0);
    waitSignal("miss_idle", 3, 1'b0, 10, t_a);
    checkOutput("miss_req_count", req_count - rq0, 1);
    checkOutput("miss_fdir_low", fdir_low_cnt - fd0, 0);
    checkOutput("miss_oe", oe_cnt - oe0, 0);

    // Refresh and INTA
    bz0 = busy_cnt; rq0 = req_count;
    applyStimulus(1, 0, 0, 0);
    waitClocks(15);
    applyStimulus(0, 1, 0, 0);
    waitClocks(15);
    applyStimulus(0, 0, 0, 0);
    waitClocks(5);
    checkOutput("refresh_busy", busy_cnt - bz0, 0);
    checkOutput("refresh_req", req_count - rq0, 0);

    // Write aborted while the high address is captured
    za = 16'hABCD; zd = 8'h11; rq0 = req_count;
    applyStimulus(1, 0, 0, 1);
    waitSignal("abort_cap_ah", 4, 1'b1, 30, t_a);
    applyStimulus(1, 0, 0, 0);
    waitClocks(10);
    applyStimulus(0, 0, 0, 0);
    waitClocks(3);
    @(negedge clk);
    checkOutput("abort_req", req_count - rq0, 0);
    checkOutput("abort_idle", 32'(busy), 0);
    checkOutput("abort_addr_lo", 32'(bus_addr[7:0]), 32'hCD);

    // Late ack after the strobe ended
    za = 16'h0042; resp_hit = 1'b1; resp_rdata = 8'hEE; ack_delay = 30;
    pushExp(16'h0042, 8'h00, 1'b0, 1'b0);
    fd0 = fdir_low_cnt; oe0 = oe_cnt; rq0 = req_count;
    applyStimulus(1, 0, 1, 0);
    waitSignal("late_req", 2, 1'b1, 40, t_a);
    waitClocks(2);
    applyStimulus(0, 0, 0, 0);
    waitSignal("late_req_done", 2, 1'b0, 60, t_b);
    checkOutput("late_req_held", 32'(t_b - t_a >= 30), 1);
    waitSignal("late_idle", 3, 1'b0, 20, t_c);
    checkOutput("late_req_count", req_count - rq0, 1);
    checkOutput("late_fdir_low", fdir_low_cnt - fd0, 0);
    checkOutput("late_oe", oe_cnt - oe0, 0);

    // Asynchronous reset while driving
    za = 16'h3C00; resp_hit = 1'b1; resp_rdata = 8'hA5; ack_delay = 0;
    pushExp(16'h3C00, 8'h00, 1'b0, 1'b1);
    applyStimulus(0, 1, 1, 0);
    waitSignal("rst_drive", 1, 1'b1, 60, t_a);
    checkOutput("rst_drive_data", 32'(fci_out), 32'hA5);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_pins", {29'h0, fci_oe, fdir, bus_req}, {29'h0, 1'b0, 1'b1, 1'b0});
    checkOutput("rst_async_busy", 32'(busy), 0);
    frd = 1'b0; fiorq = 1'b0;
    waitClocks(3); #2;
    rst_n = 1'b1;
    waitClocks(5);
    @(negedge clk);
    checkOutput("post_rst_idle", 32'(busy), 0);

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    checkOutput("fdir_oe_conflict", conflict_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
